spi_ram_ctrl: RTL and testbench

Single-port RAM controller sitting directly downstream of the SPI slave. It consumes the slave's 10-bit `rx_data`/`rx_valid` words and decodes the top two bits as a command: write-address, write-data, read-address or read-data. For read-data it returns a byte on `tx_data`/`tx_valid` for the slave to shift out on MISO.

---
 rtl/shared_pkg.sv | 23 ++
 rtl/sp_ram_array.sv | 28 ++
 rtl/spi_ram_ctrl.sv | 126 ++++++++++++
 tb/tb_spi_ram_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared types for the SPI RAM controller: command encoding and FSM states.
package shared_pkg;

    // Command carried in rx_data[9:8].
    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } ram_cmd_t;

    // Controller FSM states.
    typedef enum {
        RAM_IDLE,
        RAM_RD_FETCH,
        RAM_RD_HOLD
    } ram_state_t;

    localparam int unsigned CMD_MSB  = 9;
    localparam int unsigned CMD_LSB  = 8;
    localparam int unsigned DATA_W   = 8;

endpackage

// File: rtl/sp_ram_array.sv
// Byte-wide single-clock RAM: one write port, one registered read port, no reset.
module sp_ram_array #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [7:0]           wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [7:0]           rd_data
);

    logic [7:0] mem [MEM_DEPTH];

    // Write port and registered read; read data only updates on a read request
    // so it stays put while the controller transfers it to tx_data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// RAM controller behind the SPI slave: decodes 10-bit command words into
// address/data writes and reads, and returns read bytes on tx_data/tx_valid.
module spi_ram_ctrl
    import shared_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid
);

    ram_state_t           state;
    ram_state_t           next_state;
    ram_cmd_t             cmd;
    logic [7:0]           payload;
    logic                 rx_valid_d;
    logic                 seeded;
    logic                 accept;
    logic                 wr_en;
    logic                 rd_en;
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic [7:0]           ram_q;

    assign cmd     = ram_cmd_t'(rx_data[CMD_MSB:CMD_LSB]);
    assign payload = rx_data[DATA_W-1:0];

    // Edge detector history. The first edge after reset release only seeds
    // rx_valid_d, so a level still high from before reset is never taken as new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_d <= 1'b0;
            seeded     <= 1'b0;
        end else begin
            rx_valid_d <= rx_valid;
            seeded     <= 1'b1;
        end
    end

    // Accept one command per rising edge of rx_valid, and only when idle.
    always_comb begin
        accept = seeded && rx_valid && !rx_valid_d && (state == RAM_IDLE);
        wr_en  = accept && (cmd == CMD_WR_DATA);
        rd_en  = accept && (cmd == CMD_RD_DATA);
    end

    // Address pointers: loaded by address commands, optionally post-incremented
    // by data accesses (wraps naturally at MEM_DEPTH).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (accept) begin
            case (cmd)
                CMD_WR_ADDR: wr_ptr <= payload[ADDR_SIZE-1:0];
                CMD_WR_DATA: if (AUTO_INC != 0) wr_ptr <= wr_ptr + ADDR_SIZE'(1);
                CMD_RD_ADDR: rd_ptr <= payload[ADDR_SIZE-1:0];
                CMD_RD_DATA: if (AUTO_INC != 0) rd_ptr <= rd_ptr + ADDR_SIZE'(1);
                default: ;
            endcase
        end
    end

    sp_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (payload),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RAM_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            RAM_IDLE:     if (rd_en) next_state = RAM_RD_FETCH;
            RAM_RD_FETCH: next_state = RAM_RD_HOLD;
            RAM_RD_HOLD:  if (!rx_valid) next_state = RAM_IDLE;
            default:      next_state = RAM_IDLE;
        endcase
    end

    // Output registers: load on leaving RD_FETCH, clear valid when the slave
    // drops rx_valid; tx_data keeps its last value afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else if (state == RAM_RD_FETCH) begin
            tx_data  <= ram_q;
            tx_valid <= 1'b1;
        end else if ((state == RAM_RD_HOLD) && !rx_valid) begin
            tx_valid <= 1'b0;
        end
    end

`ifdef SIM
    a_valid_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
        tx_valid |-> (state == RAM_RD_HOLD));
    a_accept_idle: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> (state == RAM_IDLE));
    a_tx_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (tx_valid && $past(tx_valid)) |-> $stable(tx_data));
`endif

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl (AUTO_INC=1): a driver updates a plain
// array/pointer model and queues expected read bytes with their due cycle;
// a negedge monitor pops and compares whenever tx_valid rises.
module tb_spi_ram_ctrl;

    localparam logic [1:0] C_WA = 2'd0;
    localparam logic [1:0] C_WD = 2'd1;
    localparam logic [1:0] C_RA = 2'd2;
    localparam logic [1:0] C_RD = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    always #5 clk = ~clk;

    spi_ram_ctrl #(
        .MEM_DEPTH (256),
        .ADDR_SIZE (8),
        .AUTO_INC  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model
    logic [7:0]  mm [256];
    logic [7:0]  wp;
    logic [7:0]  rp;
    logic [7:0]  exp_data [$];
    int unsigned exp_cyc  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: compares every tx_valid rise against the scoreboard.
    logic       prev_v = 1'b0;
    logic [7:0] prev_d = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            check("no_x_outputs", 32'($isunknown({tx_valid, tx_data})), 32'd0);
            if (tx_valid && !prev_v) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tx: got tx_data %0h with no read pending", tx_data);
                end else begin
                    check("tx_data", 32'(tx_data), 32'(exp_data.pop_front()));
                    check("rise_cycle", cyc, exp_cyc.pop_front());
                end
            end else if (tx_valid && prev_v) begin
                check("tx_stable", 32'(tx_data), 32'(prev_d));
            end
            prev_v = tx_valid;
            prev_d = tx_data;
        end
    end

    // Issue one command with rx_valid high for 'hold' cycles, then let the
    // slave return to idle. Called just after a rising edge.
    task automatic send(input logic [1:0] c, input logic [7:0] p, input int unsigned hold);
        int unsigned acc;
        int unsigned budget;
        acc = cyc + 1;
        case (c)
            C_WA: wp = p;
            C_WD: begin mm[wp] = p; wp = wp + 8'd1; end
            C_RA: rp = p;
            default: begin
                exp_data.push_back(mm[rp]);
                exp_cyc.push_back(acc + 1);
                rp = rp + 8'd1;
            end
        endcase
        rx_data  = {c, p};
        rx_valid = 1'b1;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        if (c == C_RD) begin
            budget = 0;
            while ((tx_valid || cyc < acc + 1) && budget < 12) begin
                @(posedge clk);
                #1;
                budget++;
            end
            check("fall_cycle", cyc, acc + ((hold > 2) ? hold : 2));
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        wp       = '0;
        rp       = '0;
        #12;
        check("reset_tx_valid", 32'(tx_valid), 32'd0);
        check("reset_tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_tx_valid", 32'(tx_valid), 32'd0);

        // Fill memory so every read has a known value.
        send(C_WA, 8'h00, 1);
        for (int unsigned i = 0; i < 256; i++) send(C_WD, 8'(i * 7 + 3), 1);

        // Write then read.
        send(C_WA, 8'h12, 1);
        send(C_WD, 8'hA5, 1);
        send(C_RA, 8'h12, 1);
        send(C_RD, 8'h00, 3);

        // Held level writes exactly once: 0x41 must keep its fill value.
        send(C_WA, 8'h40, 1);
        send(C_WD, 8'h3C, 20);
        send(C_RA, 8'h40, 1);
        send(C_RD, 8'h00, 1);
        send(C_RD, 8'h00, 2);

        // Pointer wrap.
        send(C_WA, 8'hFF, 1);
        send(C_WD, 8'h11, 1);
        send(C_WD, 8'h22, 2);
        send(C_RA, 8'hFF, 1);
        send(C_RD, 8'h00, 1);
        send(C_RD, 8'h00, 4);

        // Ignored edge: low-high pulse while the read is in flight.
        acc = cyc + 1;
        exp_data.push_back(mm[rp]);
        exp_cyc.push_back(acc + 1);
        rp = rp + 8'd1;
        rx_data  = {C_RD, 8'h00};
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = {C_WD, 8'h77};
        @(posedge clk); #1;
        rx_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("ignored_edge_hold", 32'(tx_valid), 32'd1);
        rx_valid = 1'b0;
        @(posedge clk); #1;
        check("ignored_edge_fall", 32'(tx_valid), 32'd0);
        send(C_RA, wp, 1);
        send(C_RD, 8'h00, 1);

        // Reset mid-read.
        send(C_WA, 8'h55, 1);
        send(C_WD, 8'hE7, 1);
        send(C_RA, 8'h55, 1);
        acc = cyc + 1;
        exp_data.push_back(mm[rp]);
        exp_cyc.push_back(acc + 1);
        rx_data  = {C_RD, 8'h00};
        rx_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("pre_reset_tx_valid", 32'(tx_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_tx_valid", 32'(tx_valid), 32'd0);
        wp = '0;
        rp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check("held_after_reset", 32'(tx_valid), 32'd0);
        rx_valid = 1'b0;
        @(posedge clk); #1;
        send(C_RA, 8'h55, 1);
        send(C_RD, 8'h00, 2);
        send(C_WD, 8'h99, 1);
        send(C_RA, 8'h00, 1);
        send(C_RD, 8'h00, 1);

        // Random commands.
        for (int unsigned n = 0; n < 500; n++) begin
            send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), $urandom_range(1, 3));
        end

        repeat (4) begin @(posedge clk); #1; end
        check("scoreboard_empty", 32'(exp_data.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
